// File: rtl/mem_readin_demux_pkg.sv
// rtl/mem_readin_demux_pkg.sv - shared widths, stream field positions and FSM state type
// Used by the read-in demux, its per-memory counters and the bus interface.
package mem_readin_demux_pkg;

  localparam int NMEM     = 12;
  localparam int DAT_W    = 45;
  localparam int ADDR_W   = 6;
  localparam int SEL_W    = 4;
  localparam int BX_W     = 3;
  localparam int STREAM_W = 52;

  localparam int SEL_MSB  = 51;
  localparam int SEL_LSB  = 48;
  localparam int BX_MSB   = 47;
  localparam int BX_LSB   = 45;
  localparam int DATA_MSB = 44;
  localparam int DATA_LSB = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mem_readin_demux_if.sv
// rtl/mem_readin_demux_if.sv - stream input and memory-write/report bus of the demux
// The slave modport is the demux side; master is the producer/consumer around it.
interface mem_readin_demux_if;
  import mem_readin_demux_pkg::*;

  logic                     new_event;
  logic [STREAM_W-1:0]      stream_in;
  logic                     stream_valid;
  logic [NMEM-1:0]          wr_en;
  logic [NMEM*ADDR_W-1:0]   wr_addr;
  logic [BX_W-1:0]          wr_bx;
  logic [DAT_W-1:0]         wr_data;
  logic [NMEM*ADDR_W-1:0]   number_out;
  logic                     number_valid;
  logic [NMEM-1:0]          overflow;
  logic                     bad_word;

  modport slave (
    input  new_event, stream_in, stream_valid,
    output wr_en, wr_addr, wr_bx, wr_data, number_out, number_valid, overflow, bad_word
  );

  modport master (
    output new_event, stream_in, stream_valid,
    input  wr_en, wr_addr, wr_bx, wr_data, number_out, number_valid, overflow, bad_word
  );

endinterface

// File: rtl/readin_counter.sv
// rtl/readin_counter.sv - per-memory item count with saturation and sticky overflow
// A clear coinciding with a hit restarts the count so the hit lands at address 0.
module readin_counter
  import mem_readin_demux_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              hit,
  output logic              accept,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] count,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  logic [ADDR_W-1:0] count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              full;

  always_comb begin
    full    = (count_q == CNT_MAX);
    accept  = hit & (clear | ~full);
    addr    = clear ? '0 : count_q;
    count_d = addr;
    if (accept) count_d = addr + ADDR_W'(1);
    ovf_d   = ovf_q | (hit & ~clear & full);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/mem_readin_demux.sv
// rtl/mem_readin_demux.sv - routes merged stream words to 12 memories by sel, per BX event
// Words are written one cycle after arrival; counts are reported at each new event.
module mem_readin_demux
  import mem_readin_demux_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  mem_readin_demux_if.slave  bus
);

  state_t                  state_q, state_d;
  logic [BX_W-1:0]         bx_q, bx_d, eff_bx;
  logic [NMEM-1:0]         wr_en_q, wr_en_d;
  logic [NMEM*ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [BX_W-1:0]         wr_bx_q, wr_bx_d;
  logic [DAT_W-1:0]        wr_data_q, wr_data_d;
  logic [NMEM*ADDR_W-1:0]  number_out_q, number_out_d;
  logic                    number_valid_q, number_valid_d;
  logic                    bad_word_q, bad_word_d;

  logic [SEL_W-1:0]        sel;
  logic [BX_W-1:0]         sbx;
  logic [DAT_W-1:0]        sdata;
  logic                    active, new_run, word_seen, sel_ok, bx_ok;
  logic [NMEM-1:0]         hit, accept;
  logic [ADDR_W-1:0]       slot_addr [NMEM];
  logic [NMEM*ADDR_W-1:0]  counts_flat;

  assign sel   = bus.stream_in[SEL_MSB:SEL_LSB];
  assign sbx   = bus.stream_in[BX_MSB:BX_LSB];
  assign sdata = bus.stream_in[DATA_MSB:DATA_LSB];

  // A word arriving with new_event belongs to the event that starts, so BX is checked post-update.
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    active  = 1'b0;
    new_run = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.new_event) begin
        state_d = ST_RUN;
        bx_d    = sbx;
        active  = 1'b1;
      end
      ST_RUN: begin
        active = 1'b1;
        if (bus.new_event) begin
          bx_d    = bx_q + BX_W'(1);
          new_run = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    eff_bx    = bx_d;
    word_seen = active & bus.stream_valid;
    sel_ok    = (sel < SEL_W'(NMEM));
    bx_ok     = (sbx == eff_bx);
    for (int k = 0; k < NMEM; k++) begin
      hit[k] = word_seen & sel_ok & bx_ok & (sel == SEL_W'(k));
    end
    bad_word_d = word_seen & ~(sel_ok & bx_ok);
  end

  for (genvar g = 0; g < NMEM; g++) begin : g_cnt
    logic [ADDR_W-1:0] slot_count;
    logic              slot_ovf;
    readin_counter u_cnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (bus.new_event),
      .hit      (hit[g]),
      .accept   (accept[g]),
      .addr     (slot_addr[g]),
      .count    (slot_count),
      .overflow (slot_ovf)
    );
    assign counts_flat[g*ADDR_W +: ADDR_W] = slot_count;
    assign bus.overflow[g]                 = slot_ovf;
  end

  always_comb begin
    wr_en_d   = accept;
    wr_addr_d = wr_addr_q;
    for (int k = 0; k < NMEM; k++) begin
      if (accept[k]) wr_addr_d[k*ADDR_W +: ADDR_W] = slot_addr[k];
    end
    wr_data_d      = (|accept) ? sdata  : wr_data_q;
    wr_bx_d        = (|accept) ? eff_bx : wr_bx_q;
    number_out_d   = new_run ? counts_flat : number_out_q;
    number_valid_d = new_run;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      bx_q           <= '0;
      wr_en_q        <= '0;
      wr_addr_q      <= '0;
      wr_bx_q        <= '0;
      wr_data_q      <= '0;
      number_out_q   <= '0;
      number_valid_q <= 1'b0;
      bad_word_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bx_q           <= bx_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_bx_q        <= wr_bx_d;
      wr_data_q      <= wr_data_d;
      number_out_q   <= number_out_d;
      number_valid_q <= number_valid_d;
      bad_word_q     <= bad_word_d;
    end
  end

  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_bx        = wr_bx_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.number_out   = number_out_q;
  assign bus.number_valid = number_valid_q;
  assign bus.bad_word     = bad_word_q;

endmodule

// File: tb/tb_mem_readin_demux.sv
// tb/tb_mem_readin_demux.sv - scoreboard bench with directed scenarios and random traffic
// Expected writes, drops and reports are queued by a reference model and matched by a monitor.
module tb_mem_readin_demux;
  import mem_readin_demux_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_readin_demux_if bus ();

  mem_readin_demux dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    int          sel;
    int          addr;
    logic [44:0] data;
    int          bx;
  } wr_t;

  typedef struct {
    int          cyc;
    logic [71:0] cnts;
  } rep_t;

  wr_t  wq[$];
  int   bq[$];
  rep_t rq[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  int          m_cnt [12];
  logic [11:0] m_ovf;
  int          m_bx;
  bit          m_run;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    foreach (m_cnt[k]) m_cnt[k] = 0;
    m_ovf = '0;
    m_bx  = 0;
    m_run = 1'b0;
  endtask

  // Event boundary first, then the word, so a coincident word belongs to the new event.
  task automatic model(input bit ne, input bit v, input int sel, input int sbx, input logic [44:0] data);
    int   n;
    wr_t  w;
    rep_t r;
    n = cyc + 1;
    if (ne) begin
      if (m_run) begin
        r.cyc = n;
        for (int k = 0; k < 12; k++) r.cnts[k*6 +: 6] = 6'(m_cnt[k]);
        rq.push_back(r);
        m_bx = (m_bx + 1) % 8;
      end else begin
        m_run = 1'b1;
        m_bx  = sbx;
      end
      foreach (m_cnt[k]) m_cnt[k] = 0;
    end
    if (v && m_run) begin
      if (sel >= 12 || sbx != m_bx) begin
        bq.push_back(n);
      end else if (m_cnt[sel] == 63) begin
        m_ovf[sel] = 1'b1;
      end else begin
        w.cyc = n; w.sel = sel; w.addr = m_cnt[sel]; w.data = data; w.bx = m_bx;
        wq.push_back(w);
        m_cnt[sel]++;
      end
    end
  endtask

  task automatic step(input bit ne, input bit v, input int sel, input int sbx, input logic [44:0] data);
    bus.new_event    = ne;
    bus.stream_valid = v;
    bus.stream_in    = {sel[3:0], sbx[2:0], data};
    model(ne, v, sel, sbx, data);
    @(posedge clk);
    #1;
    bus.new_event    = 1'b0;
    bus.stream_valid = 1'b0;
  endtask

  task automatic word(input int sel, input int sbx);
    step(1'b0, 1'b1, sel, sbx, 45'({$urandom, $urandom}));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, '0);
  endtask

  task automatic check_ovf(input string name);
    @(negedge clk);
    check(name, bus.overflow, m_ovf);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b0;
    #2;
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_bx", bus.wr_bx, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_number_out", bus.number_out, 0);
    check("rst_number_valid", bus.number_valid, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_bad_word", bus.bad_word, 0);
    wq.delete(); bq.delete(); rq.delete();
    model_reset();
    @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.wr_en != '0) begin
        if (wq.size() == 0) begin
          check("unexpected_wr_en", bus.wr_en, 0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("wr_cycle", cyc, w.cyc);
          check("wr_en", bus.wr_en, 12'(1) << w.sel);
          check("wr_addr", bus.wr_addr[w.sel*6 +: 6], w.addr);
          check("wr_data", bus.wr_data, w.data);
          check("wr_bx", bus.wr_bx, w.bx);
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        check("missing_wr_en", bus.wr_en, 12'(1) << wq[0].sel);
        void'(wq.pop_front());
      end

      if (bus.bad_word) begin
        if (bq.size() == 0) check("unexpected_bad_word", 1, 0);
        else check("bad_word_cycle", cyc, bq.pop_front());
      end else if (bq.size() > 0 && bq[0] <= cyc) begin
        check("missing_bad_word", 0, 1);
        void'(bq.pop_front());
      end

      if (bus.number_valid) begin
        if (rq.size() == 0) begin
          check("unexpected_number_valid", 1, 0);
        end else begin
          rep_t r;
          r = rq.pop_front();
          check("report_cycle", cyc, r.cyc);
          check("number_out", bus.number_out, r.cnts);
        end
      end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        check("missing_number_valid", 0, 1);
        void'(rq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.new_event    = 1'b0;
    bus.stream_valid = 1'b0;
    bus.stream_in    = '0;
    reset            = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Basic routing and first report
    step(1'b1, 1'b0, 0, 2, '0);
    word(0, 2); word(0, 2); word(5, 2);
    idle(2);
    step(1'b1, 1'b0, 0, 0, '0);
    word(4, 3);
    idle(2);

    // Illegal sel and BX mismatch
    word(13, m_bx);
    word(1, (m_bx + 1) % 8);
    word(15, m_bx);
    idle(2);

    // New event coinciding with a word
    word(2, m_bx);
    step(1'b1, 1'b1, 7, (m_bx + 1) % 8, 45'({$urandom, $urandom}));
    idle(1);
    step(1'b1, 1'b0, 0, 0, '0);
    idle(2);

    // Overflow on memory 3
    for (int i = 0; i < 65; i++) word(3, m_bx);
    check_ovf("overflow_set");
    step(1'b1, 1'b0, 0, 0, '0);
    word(3, m_bx);
    check_ovf("overflow_sticky");
    idle(2);

    // Back-to-back sweep of all memories
    step(1'b1, 1'b0, 0, 0, '0);
    for (int s = 0; s < 12; s++) word(s, m_bx);
    idle(2);

    // Reset mid-event: partial counts never reported
    for (int i = 0; i < 10; i++) word($urandom_range(0, 11), m_bx);
    idle(2);
    check("drain_before_reset", wq.size() + bq.size() + rq.size(), 0);
    do_reset();
    for (int i = 0; i < 3; i++) word($urandom_range(0, 15), $urandom_range(0, 7));
    step(1'b1, 1'b0, 0, 5, '0);
    word(9, 5);
    step(1'b1, 1'b0, 0, 0, '0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit ne, v;
      int sel, sbx;
      ne  = ($urandom_range(0, 11) == 0);
      v   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 13);
      if ($urandom_range(0, 9) == 0) sbx = $urandom_range(0, 7);
      else sbx = ne ? (m_bx + 1) % 8 : m_bx;
      step(ne, v, sel, sbx, 45'({$urandom, $urandom}));
    end
    step(1'b1, 1'b0, 0, 0, '0);
    idle(3);
    check_ovf("overflow_final");
    check("wr_queue_drained", wq.size(), 0);
    check("bad_queue_drained", bq.size(), 0);
    check("report_queue_drained", rq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_readin_demux.md
MEM_READIN_DEMUX -- requirements
Module: mem_readin_demux

Interface
REQ-001 SHALL have port clk, input, 1, the single processing clock; all logic is on its rising edge.
REQ-002 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port new_event, input, 1: a single-cycle pulse marking the start of the next BX event.
REQ-004 SHALL have port stream_in, input, 52: the merged stream word, laid out as [51:48] sel, [47:45] BX, [44:0] data.
REQ-005 SHALL have port stream_valid, input, 1: stream_in holds a valid word this cycle.
REQ-006 SHALL have port wr_en, output, 12: per-memory write enable, bit k for memory k.
REQ-007 SHALL have port wr_addr, output, 72: the per-memory low write address; memory k uses bits [6k+5:6k].
REQ-008 SHALL have port wr_bx, output, 3: the high write address part (current BX), shared by all memories.
REQ-009 SHALL have port wr_data, output, 45: the write data, shared by all memories.
REQ-010 SHALL have port number_out, output, 72: the item count per memory for the completed event; memory k uses bits [6k+5:6k].
REQ-011 SHALL have port number_valid, output, 1: a one-cycle pulse when number_out updates.
REQ-012 SHALL have port overflow, output, 12: sticky per-memory flag, set when a memory drops a word on overflow.
REQ-013 SHALL have port bad_word, output, 1: a one-cycle pulse when a word is dropped for an illegal sel or a BX mismatch.

Function
REQ-014 SHALL implement FSM IDLE -> RUN on the first new_event; in IDLE, valid words are ignored and no error is flagged.
REQ-015 SHALL, on each new_event in RUN, increment the current BX by 1 (mod 8), latch all 12 counts into number_out, pulse number_valid on the next cycle, and clear all counts.
REQ-016 SHALL, on the first new_event (IDLE->RUN), load BX with stream_in[47:45] captured in that cycle, and keep number_valid low.
REQ-017 SHALL accept a word when stream_valid=1, sel<12, stream BX==current BX, and count[sel]<63.
REQ-018 SHALL, for an accepted word, assert wr_en[sel] exactly one cycle later, with wr_addr[sel]=count before the increment, wr_data=data, and wr_bx=current BX; count[sel] then increments.
REQ-019 SHALL drop a word with sel in 12..15 and pulse bad_word one cycle later.
REQ-020 SHALL drop a word whose BX differs from the current BX and pulse bad_word one cycle later.
REQ-021 SHALL, when count[sel]==63, drop the word, leave the count unchanged, and set overflow[sel] until reset.
REQ-022 SHALL, when new_event and a valid word coincide, assign the word to the new event: write address 0 in the new BX, new count 1; the latched counts exclude it.
REQ-023 SHALL assert at most one wr_en bit per cycle; wr_en SHALL be all-zero when no word is accepted.
REQ-024 SHALL have a latency of exactly 1 cycle from stream_in to the write outputs, with no backpressure; the input rate is up to one word per cycle.
REQ-025 SHALL hold wr_addr and wr_data at their last values when idle; only wr_en qualifies them.

Reset
REQ-026 SHALL, on reset low, asynchronously set: FSM=IDLE, all counts=0, BX=0, wr_en=0, wr_addr=0, wr_bx=0, wr_data=0, number_out=0, number_valid=0, overflow=0, bad_word=0.
REQ-027 SHALL, when reset deasserts mid-event, restart in IDLE; the partial event's counts are discarded and never reported.

Structure
REQ-028 SHALL take from a shared package: NMEM=12, DAT_W=45, ADDR_W=6, SEL_W=4, BX_W=3, STREAM_W=52, the field-position constants, and the FSM state typedef.
REQ-029 SHALL instantiate sub-module readin_counter 12 times; each instance holds the 6-bit count, the saturation detect, and the overflow flag.

Verification
REQ-030 Basic: reset, new_event with stream BX=2, then words sel=0,0,5 -> wr_en[0] at addr 0 then 1, wr_en[5] addr 0, wr_bx=2; next new_event -> number_out mem0=2, mem5=1, all others 0, number_valid pulse, BX=3.
REQ-031 Overflow: 65 words to sel=3 -> 63 writes (addr 0..62), overflow[3]=1, count reported 63, later events still write mem3 with the flag still set.
REQ-032 Illegal: sel=13 word, then a word with BX=current+1 -> no wr_en, two bad_word pulses, counts unchanged.
REQ-033 Coincidence: new_event with a valid sel=7 word in the same cycle -> old counts exclude it; wr_en[7] at addr 0 with the new BX; the next report shows mem7=1.
REQ-034 Reset mid-event: 10 words, then reset low for 1 cycle -> all outputs 0, IDLE; words ignored until new_event; no number_valid for the aborted event.
REQ-035 Back-to-back: 12 consecutive words, sel=0..11, one per cycle -> 12 single-bit wr_en pulses in consecutive cycles, each at addr 0.
